// File: rtl/dest_ip_filter_multi.sv
// ============================================================================
// dest_ip_filter_multi - flop-based multi-entry IPv4 destination filter with
// queued {hit,index} results. Optional: DEST_IP_FILTER_HIT_CNT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module dest_ip_filter_multi #(
  parameter int DATA_WIDTH      = 64,
  parameter int LUT_DEPTH       = 32,
  parameter int LUT_DEPTH_BITS  = $clog2(LUT_DEPTH),
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      word_IP_SRC_DST,
  input  logic                      word_IP_DST_LO,
  output logic                      dest_ip_hit,
  output logic [LUT_DEPTH_BITS-1:0] dest_ip_hit_index,
  output logic                      dest_ip_filter_vld,
  input  logic                      rd_dest_ip_filter_result,
  output logic                      dest_ip_filter_overflow,
  input  logic [LUT_DEPTH_BITS-1:0] dest_ip_filter_rd_addr,
  input  logic                      dest_ip_filter_rd_req,
  output logic [31:0]               dest_ip_filter_rd_ip,
  output logic [31:0]               dest_ip_filter_rd_mask,
  output logic [31:0]               dest_ip_filter_rd_hits,
  output logic                      dest_ip_filter_rd_ack,
  input  logic [LUT_DEPTH_BITS-1:0] dest_ip_filter_wr_addr,
  input  logic                      dest_ip_filter_wr_req,
  input  logic [31:0]               dest_ip_filter_wr_ip,
  input  logic [31:0]               dest_ip_filter_wr_mask,
  output logic                      dest_ip_filter_wr_ack
);

  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;

  logic [31:0]                r_ip   [LUT_DEPTH];
  logic [31:0]                r_mask [LUT_DEPTH];
  logic [LUT_DEPTH-1:0]       r_valid;
  logic [31:0]                r_dst;
  logic                       r_lkup_vld;
  logic [LUT_DEPTH-1:0]       r_match;
  logic                       r_match_vld;
  logic                       w_hit;
  logic [LUT_DEPTH_BITS-1:0]  w_idx;
  logic [LUT_DEPTH_BITS:0]    r_fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   r_count;
  logic                       r_overflow;
  logic                       w_empty;
  logic                       w_full;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_drop;
  logic [LUT_DEPTH_BITS:0]    w_head;
  logic [31:0]                w_rd_ip;
  logic [31:0]                w_rd_mask;
  logic [31:0]                w_rd_hits;
  logic [31:0]                r_rd_ip;
  logic [31:0]                r_rd_mask;
  logic [31:0]                r_rd_hits;
  logic                       r_rd_ack;
  logic                       r_wr_ack;
  logic                       w_unused;

  assign w_unused = ^in_data[DATA_WIDTH-17:16];

  // Header capture: DA hi and lo may arrive in separate or the same beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dst      <= '0;
      r_lkup_vld <= 1'b0;
    end else begin
      if (word_IP_SRC_DST) r_dst[31:16] <= in_data[15:0];
      if (word_IP_DST_LO)  r_dst[15:0]  <= in_data[DATA_WIDTH-1 -: 16];
      r_lkup_vld <= word_IP_DST_LO;
    end
  end

  // Table storage; an out-of-range write address matches no entry and is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < LUT_DEPTH; i++) begin
        r_ip[i]   <= '0;
        r_mask[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        if (dest_ip_filter_wr_req && dest_ip_filter_wr_addr == LUT_DEPTH_BITS'(i)) begin
          r_ip[i]    <= dest_ip_filter_wr_ip;
          r_mask[i]  <= dest_ip_filter_wr_mask;
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_match     <= '0;
      r_match_vld <= 1'b0;
    end else begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        r_match[i] <= r_valid[i] && (((r_dst ^ r_ip[i]) & ~r_mask[i]) == 32'd0);
      end
      r_match_vld <= r_lkup_vld;
    end
  end

  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
      if (r_match[i]) begin
        w_hit = 1'b1;
        w_idx = LUT_DEPTH_BITS'(i);
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (FIFO_DEPTH_BITS + 1)'(FIFO_DEPTH));
  assign w_pop   = rd_dest_ip_filter_result && !w_empty;
  assign w_push  = r_match_vld && (!w_full || w_pop);
  assign w_drop  = r_match_vld && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= {w_hit, w_idx};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_BITS'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_BITS'(1);
      if (w_push && !w_pop)      r_count <= r_count + (FIFO_DEPTH_BITS + 1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (FIFO_DEPTH_BITS + 1)'(1);
      r_overflow <= w_drop;
    end
  end

  // Head is gated so the outputs read zero whenever nothing is queued.
  assign w_head             = r_fifo_mem[r_rd_ptr];
  assign dest_ip_filter_vld = !w_empty;
  assign dest_ip_hit        = !w_empty && w_head[LUT_DEPTH_BITS];
  assign dest_ip_hit_index  = w_empty ? '0 : w_head[LUT_DEPTH_BITS-1:0];
  assign dest_ip_filter_overflow = r_overflow;

`ifdef DEST_IP_FILTER_HIT_CNT_EN
  logic [31:0] r_hits [LUT_DEPTH];

  // A rewrite of an entry takes precedence over a concurrent hit increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) r_hits[i] <= '0;
    end else begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        if (dest_ip_filter_wr_req && dest_ip_filter_wr_addr == LUT_DEPTH_BITS'(i)) begin
          r_hits[i] <= '0;
        end else if (r_match_vld && w_hit && w_idx == LUT_DEPTH_BITS'(i) &&
                     r_hits[i] != 32'hFFFF_FFFF) begin
          r_hits[i] <= r_hits[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    w_rd_hits = '0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (dest_ip_filter_rd_addr == LUT_DEPTH_BITS'(i)) w_rd_hits = r_hits[i];
    end
  end
`else
  assign w_rd_hits = '0;
`endif

  always_comb begin
    w_rd_ip   = '0;
    w_rd_mask = '0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (dest_ip_filter_rd_addr == LUT_DEPTH_BITS'(i)) begin
        w_rd_ip   = r_ip[i];
        w_rd_mask = r_mask[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ip   <= '0;
      r_rd_mask <= '0;
      r_rd_hits <= '0;
      r_rd_ack  <= 1'b0;
      r_wr_ack  <= 1'b0;
    end else begin
      r_rd_ack <= dest_ip_filter_rd_req;
      r_wr_ack <= dest_ip_filter_wr_req;
      if (dest_ip_filter_rd_req) begin
        r_rd_ip   <= w_rd_ip;
        r_rd_mask <= w_rd_mask;
        r_rd_hits <= w_rd_hits;
      end
    end
  end

  assign dest_ip_filter_rd_ip   = r_rd_ip;
  assign dest_ip_filter_rd_mask = r_rd_mask;
  assign dest_ip_filter_rd_hits = r_rd_hits;
  assign dest_ip_filter_rd_ack  = r_rd_ack;
  assign dest_ip_filter_wr_ack  = r_wr_ack;

endmodule

`default_nettype wire

// File: tb/tb_dest_ip_filter_multi.sv
// ============================================================================
// tb_dest_ip_filter_multi - directed + randomized bench with a queue-based
// reference model of the filter. Rev 1.0
// ============================================================================
`default_nettype none

module tb_dest_ip_filter_multi;

  localparam int DW  = 64;
  localparam int LUT = 24;
  localparam int AB  = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          word_IP_SRC_DST = 1'b0;
  logic          word_IP_DST_LO = 1'b0;
  logic          dest_ip_hit;
  logic [AB-1:0] dest_ip_hit_index;
  logic          dest_ip_filter_vld;
  logic          rd_res = 1'b0;
  logic          dest_ip_filter_overflow;
  logic [AB-1:0] rd_addr = '0;
  logic          rd_req = 1'b0;
  logic [31:0]   rd_ip, rd_mask, rd_hits;
  logic          rd_ack;
  logic [AB-1:0] wr_addr = '0;
  logic          wr_req = 1'b0;
  logic [31:0]   wr_ip = '0, wr_mask = '0;
  logic          wr_ack;

  dest_ip_filter_multi #(
    .DATA_WIDTH(DW), .LUT_DEPTH(LUT), .LUT_DEPTH_BITS(AB), .FIFO_DEPTH_BITS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data),
    .word_IP_SRC_DST(word_IP_SRC_DST), .word_IP_DST_LO(word_IP_DST_LO),
    .dest_ip_hit(dest_ip_hit), .dest_ip_hit_index(dest_ip_hit_index),
    .dest_ip_filter_vld(dest_ip_filter_vld),
    .rd_dest_ip_filter_result(rd_res),
    .dest_ip_filter_overflow(dest_ip_filter_overflow),
    .dest_ip_filter_rd_addr(rd_addr), .dest_ip_filter_rd_req(rd_req),
    .dest_ip_filter_rd_ip(rd_ip), .dest_ip_filter_rd_mask(rd_mask),
    .dest_ip_filter_rd_hits(rd_hits), .dest_ip_filter_rd_ack(rd_ack),
    .dest_ip_filter_wr_addr(wr_addr), .dest_ip_filter_wr_req(wr_req),
    .dest_ip_filter_wr_ip(wr_ip), .dest_ip_filter_wr_mask(wr_mask),
    .dest_ip_filter_wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit hit; int idx;} res_t;

  logic [31:0] m_ip [32];
  logic [31:0] m_mask [32];
  bit          m_valid [32];
  logic [31:0] m_cnt [32];
  logic [31:0] m_dst;
  res_t        pend[$];
  res_t        fifo[$];
  bit          e_ovf, e_rd_ack, e_wr_ack;
  logic [31:0] e_rd_ip, e_rd_mask, e_rd_hits;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void model_lookup(input logic [31:0] d, output bit h, output int ix);
    h = 1'b0;
    ix = 0;
    for (int i = LUT - 1; i >= 0; i--) begin
      if (m_valid[i] && ((d ^ m_ip[i]) & ~m_mask[i]) == 32'd0) begin
        h = 1'b1;
        ix = i;
      end
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_ip[i] = '0; m_mask[i] = '0; m_valid[i] = 1'b0; m_cnt[i] = '0;
    end
    m_dst = '0;
    pend.delete();
    fifo.delete();
    e_ovf = 0; e_rd_ack = 0; e_wr_ack = 0;
    e_rd_ip = '0; e_rd_mask = '0; e_rd_hits = '0;
  endtask

  task automatic clear_inputs();
    word_IP_SRC_DST = 0; word_IP_DST_LO = 0; rd_res = 0; rd_req = 0; wr_req = 0;
  endtask

  // One clock cycle: model the effect of the coming edge, advance, check outputs.
  task automatic step();
    bit n_rd_ack, n_ovf, h;
    int ix;
    logic [31:0] n_ip, n_mask, n_hits;
    res_t r;
    n_rd_ack = rd_req;
    n_ip = '0; n_mask = '0; n_hits = '0;
    if (rd_req && int'(rd_addr) < LUT) begin
      n_ip = m_ip[rd_addr]; n_mask = m_mask[rd_addr];
`ifdef DEST_IP_FILTER_HIT_CNT_EN
      n_hits = m_cnt[rd_addr];
`endif
    end
    if (!rd_req) begin
      n_ip = e_rd_ip; n_mask = e_rd_mask; n_hits = e_rd_hits;
    end
    if (rd_res && fifo.size() > 0) void'(fifo.pop_front());
    n_ovf = 1'b0;
    while (pend.size() > 0 && pend[0].cyc == cyc) begin
      r = pend.pop_front();
      if (fifo.size() < 4) fifo.push_back(r);
      else n_ovf = 1'b1;
      if (r.hit && m_cnt[r.idx] != 32'hFFFF_FFFF) m_cnt[r.idx] = m_cnt[r.idx] + 1;
    end
    if (wr_req && int'(wr_addr) < LUT) begin
      m_ip[wr_addr] = wr_ip; m_mask[wr_addr] = wr_mask;
      m_valid[wr_addr] = 1'b1; m_cnt[wr_addr] = '0;
    end
    if (word_IP_SRC_DST) m_dst[31:16] = in_data[15:0];
    if (word_IP_DST_LO) begin
      m_dst[15:0] = in_data[63:48];
      model_lookup(m_dst, h, ix);
      pend.push_back('{cyc + 2, h, ix});
    end
    e_wr_ack = wr_req;
    @(negedge clk);
    cyc++;
    e_rd_ack = n_rd_ack; e_ovf = n_ovf;
    e_rd_ip = n_ip; e_rd_mask = n_mask; e_rd_hits = n_hits;
    clear_inputs();
    check("vld", dest_ip_filter_vld, fifo.size() > 0);
    check("hit", dest_ip_hit, fifo.size() > 0 ? fifo[0].hit : 1'b0);
    check("index", dest_ip_hit_index, fifo.size() > 0 ? fifo[0].idx : 0);
    check("overflow", dest_ip_filter_overflow, e_ovf);
    check("wr_ack", wr_ack, e_wr_ack);
    check("rd_ack", rd_ack, e_rd_ack);
    if (e_rd_ack) begin
      check("rd_ip", rd_ip, e_rd_ip);
      check("rd_mask", rd_mask, e_rd_mask);
      check("rd_hits", rd_hits, e_rd_hits);
    end
  endtask

  task automatic lookup(input logic [31:0] d);
    in_data = {d[15:0], 32'($urandom), d[31:16]};
    word_IP_SRC_DST = 1; word_IP_DST_LO = 1;
  endtask

  task automatic wr(input int a, input logic [31:0] ip, input logic [31:0] mask);
    wr_addr = AB'(a); wr_ip = ip; wr_mask = mask; wr_req = 1;
  endtask

  task automatic rd(input int a);
    rd_addr = AB'(a); rd_req = 1;
  endtask

  task automatic do_reset(input int hold);
    clear_inputs();
    reset_n = 0;
    #1;
    model_clear();
    check("rst_vld", dest_ip_filter_vld, 0);
    check("rst_hit", dest_ip_hit, 0);
    check("rst_ovf", dest_ip_filter_overflow, 0);
    check("rst_acks", {rd_ack, wr_ack}, 0);
    check("rst_rd_data", {rd_ip, rd_mask}, 0);
    repeat (hold) @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    logic [31:0] ipool, mpick, lo_d, hi_d;
    model_clear();
    @(negedge clk);
    do_reset(2);

    // Empty table: lookup misses, result at T+3.
    lookup(32'h0A00_0001); step(); step();
    check("t1_vld_T2", dest_ip_filter_vld, 0);
    step();
    check("t1_vld_T3", dest_ip_filter_vld, 1);
    check("t1_hit", dest_ip_hit, 0);
    check("t1_idx", dest_ip_hit_index, 0);
    rd_res = 1; step();

    wr(3, 32'h0A00_0001, 32'h0); step();
    lookup(32'h0A00_0001); step(); step(); step();
    check("t2_hit", dest_ip_hit, 1);
    check("t2_idx", dest_ip_hit_index, 3);
    rd_res = 1; step();

    wr(1, 32'h0A00_0000, 32'h0000_00FF); step();
    lookup(32'h0A00_0001); step(); step(); step();
    check("t3_idx", dest_ip_hit_index, 1);
    rd_res = 1; step();

    // Five back-to-back lookups with no pops: fifth result is dropped.
    wr(5, 32'h0B00_0000, 32'h0); step();
    lookup(32'h0B00_0000); step();
    lookup(32'h0A00_0007); step();
    lookup(32'h0C00_0000); step();
    lookup(32'h0B00_0000); step();
    lookup(32'h0A00_0001); step();
    step(); step();
    check("t4_ovf", dest_ip_filter_overflow, 1);
    check("t4_head_idx", dest_ip_hit_index, 5);
    step();
    check("t4_ovf_pulse", dest_ip_filter_overflow, 0);
    repeat (4) begin rd_res = 1; step(); end
    check("t4_drained", dest_ip_filter_vld, 0);

    // Simultaneous read/write of one entry returns the pre-write value.
    wr(2, 32'h0C00_0002, 32'h0000_000F); step();
    wr(2, 32'h0C00_0022, 32'h0); rd(2); step();
    check("t5_old_ip", rd_ip, 32'h0C00_0002);
    rd(2); step();
    check("t5_new_ip", rd_ip, 32'h0C00_0022);
    rd(30); step();
    check("t5_oor_rd", rd_ip, 0);

    // Hit counting, and its clear on rewrite.
    wr(3, 32'h0D00_0003, 32'h0); step();
    repeat (3) begin lookup(32'h0D00_0003); step(); end
    repeat (3) begin rd_res = 1; step(); end
    rd(3); step();
`ifdef DEST_IP_FILTER_HIT_CNT_EN
    check("t6_hits3", rd_hits, 3);
`else
    check("t6_hits_off", rd_hits, 0);
`endif
    wr(3, 32'h0D00_0003, 32'h0); step();
    rd(3); step();
    check("t6_hits_clr", rd_hits, 0);
`ifdef DEST_IP_FILTER_HIT_CNT_EN
    wr(6, 32'h0E00_0006, 32'h0); step();
    dut.r_hits[6] = 32'hFFFF_FFFF; m_cnt[6] = 32'hFFFF_FFFF;
    lookup(32'h0E00_0006); step(); step(); step(); step();
    rd(6); rd_res = 1; step();
    check("t7_sat", rd_hits, 32'hFFFF_FFFF);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        ipool = {8'h0A, 16'h0000, 8'($urandom_range(0, 15))};
        case ($urandom_range(0, 3))
          0: mpick = 32'h0;
          1: mpick = 32'h0000_0003;
          2: mpick = 32'h0000_00FF;
          default: mpick = 32'($urandom) & 32'h00FF_FFFF;
        endcase
        wr(int'($urandom_range(0, 31)), ipool, mpick);
      end
      if ($urandom_range(0, 3) == 0) rd(int'($urandom_range(0, 31)));
      hi_d = {8'h0A, 8'($urandom_range(0, 1)), 16'h0};
      lo_d = {16'h0, 8'h00, 8'($urandom_range(0, 15))};
      in_data = {lo_d[15:0], 32'($urandom), hi_d[31:16]};
      word_IP_SRC_DST = ($urandom_range(0, 1) == 0);
      word_IP_DST_LO  = ($urandom_range(0, 1) == 0);
      rd_res = ($urandom_range(0, 2) != 0);
      step();
    end

    // Reset in the middle of in-flight lookups and requests.
    lookup(32'h0A00_0001); step();
    lookup(32'h0A00_0002); wr(4, 32'h1, 32'h0); rd(4); step();
    do_reset(1);
    check("t8_vld_now", dest_ip_filter_vld, 0);
    repeat (6) step();
    check("t8_no_stale", dest_ip_filter_vld, 0);
    rd(4); step();
    check("t8_tbl_clr", rd_ip, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
